// File: rtl/fc_input_buffer.sv
// Packs N_IN signed activations from a valid/ready stream into one frame for the FC stage,
// strobes fc_enable, and holds the frame until fc_done or a watchdog abort.
module fc_input_buffer #(
    parameter int N_IN    = 9,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_last,
    output logic                     fc_enable,
    output logic [N_IN*DATA_W-1:0]   fc_input_flat,
    input  logic                     fc_done,
    output logic                     busy,
    output logic [CNT_W-1:0]         frame_cnt,
    output logic                     err_len,
    output logic                     err_timeout
);
    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int WD_W  = $clog2(TIMEOUT);

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]                   r_state;
    logic [IDX_W-1:0]             r_idx;
    logic [WD_W-1:0]              r_wdog;
    logic [N_IN-1:0][DATA_W-1:0]  r_buf;
    logic [CNT_W-1:0]             r_frame_cnt;
    logic                         r_err_len;
    logic                         r_err_timeout;

    logic w_xfer;
    logic w_idx_last;
    logic w_wd_exp;

    assign in_ready      = (r_state == S_FILL) && rst;
    assign w_xfer        = in_valid && in_ready;
    assign w_idx_last    = (r_idx == IDX_W'(N_IN - 1));
    assign w_wd_exp      = (r_wdog == WD_W'(TIMEOUT - 1));

    assign fc_enable     = (r_state == S_ISSUE);
    assign busy          = (r_state != S_FILL);
    assign fc_input_flat = r_buf;
    assign frame_cnt     = r_frame_cnt;
    assign err_len       = r_err_len;
    assign err_timeout   = r_err_timeout;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_FILL;
            r_idx         <= '0;
            r_wdog        <= '0;
            r_buf         <= '0;
            r_frame_cnt   <= '0;
            r_err_len     <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_len     <= 1'b0;
            r_err_timeout <= 1'b0;
            case (r_state)
                S_FILL: begin
                    if (w_xfer) begin
                        r_buf[r_idx] <= in_data;
                        if (w_idx_last) begin
                            // Over-long input: close this frame, the rest starts the next one.
                            r_state   <= S_ISSUE;
                            r_idx     <= '0;
                            r_err_len <= !in_last;
                        end else if (in_last) begin
                            for (int i = 0; i < N_IN; i++) begin
                                if (IDX_W'(i) > r_idx) r_buf[i] <= '0;
                            end
                            r_state   <= S_ISSUE;
                            r_idx     <= '0;
                            r_err_len <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_wdog  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // fc_done takes priority over an expiring watchdog.
                    if (fc_done) begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                        r_buf       <= '0;
                        r_idx       <= '0;
                        r_state     <= S_FILL;
                    end else if (w_wd_exp) begin
                        r_err_timeout <= 1'b1;
                        r_buf         <= '0;
                        r_idx         <= '0;
                        r_state       <= S_FILL;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end
endmodule
